// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle between the multicycle controller and the RV32I datapath/memory.
// master = controller, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;

  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        instret;
  logic        illegal;
  logic        bus_err;
  logic [2:0]  state_o;

  modport master (
    input  instr, mem_ready, branch_taken,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we,
           wb_sel, alu_src_b, alu_op, instret, illegal, bus_err, state_o
  );

  modport slave (
    output instr, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we,
           wb_sel, alu_src_b, alu_op, instret, illegal, bus_err, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over one
// shared memory port and drives every datapath enable and mux select.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    OC_NONE, OC_LOAD, OC_OPIMM, OC_OP, OC_STORE, OC_BRANCH, OC_JAL, OC_LUI
  } opclass_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       instret;
  } ctl_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  state_e          state_q, state_d;
  opclass_e        opclass_q, opclass_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;

  opclass_e        dec_class;
  logic            dec_illegal;
  logic            to_expired;
  ctl_t            ctl;
  logic            unused_instr;

  // {alu_op, alu_src_b} for an opclass; WB keeps the same values EXEC produced.
  function automatic logic [2:0] alu_ctrl(input opclass_e oc);
    case (oc)
      OC_OP:              return 3'b10_0;
      OC_OPIMM:           return 3'b10_1;
      OC_LOAD, OC_STORE:  return 3'b00_1;
      OC_LUI:             return 3'b11_1;
      OC_BRANCH:          return 3'b01_0;
      default:            return 3'b00_0;
    endcase
  endfunction

  assign unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};
  assign to_expired   = (to_q == TO_W'(MEM_TIMEOUT));

  always_comb begin
    dec_class   = OC_NONE;
    dec_illegal = 1'b0;
    case (bus.instr[6:0])
      OPC_LOAD:   dec_class = OC_LOAD;
      OPC_OPIMM:  dec_class = OC_OPIMM;
      OPC_OP:     dec_class = OC_OP;
      OPC_STORE:  dec_class = OC_STORE;
      OPC_JAL:    dec_class = OC_JAL;
      OPC_LUI:    dec_class = OC_LUI;
      OPC_BRANCH: begin
        if (bus.instr[14:13] == 2'b01) dec_illegal = 1'b1;
        else                           dec_class   = OC_BRANCH;
      end
      default:    dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    opclass_d = opclass_q;
    to_d      = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    ctl       = '0;

    case (state_q)
      FETCH: begin
        ctl.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctl.ir_we = 1'b1;
          state_d   = DECODE;
        end else if (to_expired) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      DECODE: begin
        opclass_d = dec_class;
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        {ctl.alu_op, ctl.alu_src_b} = alu_ctrl(opclass_q);
        case (opclass_q)
          OC_LOAD, OC_STORE:              state_d = MEM;
          OC_OP, OC_OPIMM, OC_LUI, OC_JAL: state_d = WB;
          OC_BRANCH: begin
            ctl.pc_we   = 1'b1;
            ctl.pc_sel  = bus.branch_taken;
            ctl.instret = 1'b1;
            state_d     = FETCH;
          end
          default:                        state_d = FETCH;
        endcase
      end

      MEM: begin
        ctl.mem_req      = 1'b1;
        ctl.mem_addr_sel = 1'b1;
        ctl.alu_src_b    = 1'b1;
        ctl.mem_we       = (opclass_q == OC_STORE);
        if (bus.mem_ready) begin
          if (opclass_q == OC_STORE) begin
            ctl.pc_we   = 1'b1;
            ctl.instret = 1'b1;
            state_d     = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (to_expired) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      WB: begin
        {ctl.alu_op, ctl.alu_src_b} = alu_ctrl(opclass_q);
        ctl.reg_we  = 1'b1;
        ctl.pc_we   = 1'b1;
        ctl.instret = 1'b1;
        ctl.pc_sel  = (opclass_q == OC_JAL);
        case (opclass_q)
          OC_LOAD: ctl.wb_sel = 2'd1;
          OC_JAL:  ctl.wb_sel = 2'd2;
          OC_LUI:  ctl.wb_sel = 2'd3;
          default: ctl.wb_sel = 2'd0;
        endcase
        state_d = FETCH;
      end

      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      opclass_q <= OC_NONE;
      to_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q   <= state_d;
      opclass_q <= opclass_d;
      to_q      <= to_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Reset state is FETCH, whose outputs are non-zero, so the strobes are gated by reset.
  ctl_t ctl_out;
  assign ctl_out = reset ? '0 : ctl;

  assign bus.mem_req      = ctl_out.mem_req;
  assign bus.mem_we       = ctl_out.mem_we;
  assign bus.mem_addr_sel = ctl_out.mem_addr_sel;
  assign bus.ir_we        = ctl_out.ir_we;
  assign bus.pc_we        = ctl_out.pc_we;
  assign bus.pc_sel       = ctl_out.pc_sel;
  assign bus.reg_we       = ctl_out.reg_we;
  assign bus.wb_sel       = ctl_out.wb_sel;
  assign bus.alu_src_b    = ctl_out.alu_src_b;
  assign bus.alu_op       = ctl_out.alu_op;
  assign bus.instret      = ctl_out.instret;
  assign bus.illegal      = illegal_q;
  assign bus.bus_err      = bus_err_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction
// streams, each expanded by a transaction-level model into expected per-cycle outputs.
module tb_multicycle_ctrl;

  localparam int MT = 15;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       src_b;
    logic [1:0] alu_op;
    logic       instret;
    logic       illegal;
    logic       bus_err;
  } obs_t;

  typedef struct {
    logic        ready;
    logic        taken;
    logic [31:0] instr;
    obs_t        exp;
  } cyc_t;

  logic clk;
  logic reset;
  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .TO_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests_run = 0;
  int   tests_failed = 0;
  cyc_t q[$];
  bit   m_illegal = 1'b0;
  bit   m_buserr  = 1'b0;

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h (st=%0d) expected %h (st=%0d)", tag, got, got.st, exp, exp.st);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st       = bus.state_o;
    o.mem_req  = bus.mem_req;
    o.mem_we   = bus.mem_we;
    o.addr_sel = bus.mem_addr_sel;
    o.ir_we    = bus.ir_we;
    o.pc_we    = bus.pc_we;
    o.pc_sel   = bus.pc_sel;
    o.reg_we   = bus.reg_we;
    o.wb_sel   = bus.wb_sel;
    o.src_b    = bus.alu_src_b;
    o.alu_op   = bus.alu_op;
    o.instret  = bus.instret;
    o.illegal  = bus.illegal;
    o.bus_err  = bus.bus_err;
    return o;
  endfunction

  function automatic bit rbit();
    return 1'($urandom());
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e         = '0;
    e.st      = st;
    e.illegal = m_illegal;
    e.bus_err = m_buserr;
    return e;
  endfunction

  // ALU controls an instruction class uses in EXEC (and keeps through WB).
  function automatic obs_t with_alu(input obs_t e_in, input logic [6:0] op);
    obs_t e;
    e = e_in;
    case (op)
      OPR:     begin e.alu_op = 2'b10; e.src_b = 1'b0; end
      OPI:     begin e.alu_op = 2'b10; e.src_b = 1'b1; end
      LD, ST:  begin e.alu_op = 2'b00; e.src_b = 1'b1; end
      LUI:     begin e.alu_op = 2'b11; e.src_b = 1'b1; end
      BR:      begin e.alu_op = 2'b01; e.src_b = 1'b0; end
      default: begin e.alu_op = 2'b00; e.src_b = 1'b0; end
    endcase
    return e;
  endfunction

  function automatic bit legal(input logic [31:0] ins);
    case (ins[6:0])
      LD, OPI, OPR, ST, JAL, LUI: return 1'b1;
      BR:      return !(ins[14:12] == 3'b010 || ins[14:12] == 3'b011);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [7] = '{LD, OPI, OPR, ST, BR, JAL, LUI};
    logic [2:0]  f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r       = $urandom();
    r[6:0]  = ops[$urandom_range(0, 6)];
    if (r[6:0] == BR) r[14:12] = f3s[$urandom_range(0, 5)];
    return r;
  endfunction

  task automatic push(input logic rdy, input logic tk, input logic [31:0] ins, input obs_t e);
    cyc_t c;
    c.ready = rdy;
    c.taken = tk;
    c.instr = ins;
    c.exp   = e;
    q.push_back(c);
  endtask

  // Expand one instruction into expected cycles; fw/mw are wait cycles before mem_ready.
  task automatic gen(input logic [31:0] ins, input int fw, input int mw, input bit taken,
                     output bit trapped);
    obs_t       e;
    bit         rdy;
    logic [6:0] op;
    op      = ins[6:0];
    trapped = 1'b0;

    for (int i = 0; i <= fw; i++) begin
      rdy     = (i == fw);
      e       = blank(3'd0);
      e.mem_req = 1'b1;
      e.ir_we = rdy;
      push(rdy, rbit(), ins, e);
      if (!rdy && i == MT) begin m_buserr = 1'b1; trapped = 1'b1; return; end
    end

    push(rbit(), rbit(), ins, blank(3'd1));
    if (!legal(ins)) begin m_illegal = 1'b1; trapped = 1'b1; return; end

    e = with_alu(blank(3'd2), op);
    if (op == BR) begin
      e.pc_we   = 1'b1;
      e.pc_sel  = taken;
      e.instret = 1'b1;
      push(rbit(), taken, $urandom(), e);
      return;
    end
    push(rbit(), rbit(), $urandom(), e);

    if (op == LD || op == ST) begin
      for (int i = 0; i <= mw; i++) begin
        rdy        = (i == mw);
        e          = blank(3'd3);
        e.mem_req  = 1'b1;
        e.addr_sel = 1'b1;
        e.src_b    = 1'b1;
        e.mem_we   = (op == ST);
        if (rdy && op == ST) begin e.pc_we = 1'b1; e.instret = 1'b1; end
        push(rdy, rbit(), $urandom(), e);
        if (!rdy && i == MT) begin m_buserr = 1'b1; trapped = 1'b1; return; end
        if (rdy && op == ST) return;
      end
    end

    e         = with_alu(blank(3'd4), op);
    e.reg_we  = 1'b1;
    e.pc_we   = 1'b1;
    e.instret = 1'b1;
    case (op)
      LD:      e.wb_sel = 2'd1;
      JAL:     begin e.wb_sel = 2'd2; e.pc_sel = 1'b1; end
      LUI:     e.wb_sel = 2'd3;
      default: e.wb_sel = 2'd0;
    endcase
    push(rbit(), rbit(), $urandom(), e);
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) push(rbit(), rbit(), $urandom(), blank(3'd7));
  endtask

  // Entered and left #1 after a rising edge; inputs are applied, then outputs sampled.
  task automatic run(input string name, input int limit);
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0 && (limit < 0 || n < limit)) begin
      c = q.pop_front();
      bus.mem_ready    = c.ready;
      bus.branch_taken = c.taken;
      bus.instr        = c.instr;
      #1;
      check($sformatf("%s[%0d]", name, n), sample(), c.exp);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset(input string name);
    obs_t z;
    z = '0;
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b1;
    reset            = 1'b1;
    #1;
    check({name, "_now"}, sample(), z);
    @(posedge clk);
    #1;
    check({name, "_held"}, sample(), z);
    reset     = 1'b0;
    m_illegal = 1'b0;
    m_buserr  = 1'b0;
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit tr;
    reset            = 1'b1;
    bus.instr        = '0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    gen(32'h00500093, 0, 0, 1'b0, tr);
    run("addi", -1);

    gen(32'h0000A103, 0, 3, 1'b0, tr);
    run("lw_wait3", -1);

    gen(32'h00000463, 0, 0, 1'b1, tr);
    gen(32'h00000463, 0, 0, 1'b0, tr);
    run("beq", -1);

    gen(32'h0000007F, 0, 0, 1'b0, tr);
    trap_cycles(20);
    run("ill_opc", -1);
    do_reset("rst_ill");

    gen(32'h00002063, 1, 0, 1'b0, tr);
    trap_cycles(20);
    run("ill_br", -1);
    do_reset("rst_illbr");
    gen(32'h00500093, 0, 0, 1'b0, tr);
    run("after_ill", -1);

    gen(32'h00500093, MT + 1, 0, 1'b0, tr);
    trap_cycles(5);
    run("fetch_to", -1);
    do_reset("rst_to");

    gen(32'h00500093, MT, 0, 1'b0, tr);
    run("fetch_edge", -1);

    gen(32'h0000A103, 0, MT + 1, 1'b0, tr);
    trap_cycles(3);
    run("mem_to", -1);
    do_reset("rst_mto");

    gen(32'h0020A023, 0, 6, 1'b0, tr);
    run("sw_abort", 4);
    do_reset("rst_sw");
    gen(32'h0020A023, 0, 0, 1'b0, tr);
    gen(32'h00500093, 0, 0, 1'b0, tr);
    run("post_sw", -1);

    repeat (80) begin
      gen(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rbit(), tr);
      run("rnd", -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences one shared memory port, the ALU and the immediate path through the fetch, decode, execute, memory and writeback phases.
- It latches an opcode class in DECODE and drives all datapath enables and muxes, including the ALU B-operand select between rs2 and the sign-extended immediate.
- It sits between the instruction register, the datapath and the memory interface.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready before a bus-error trap. Legal range 1..255.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- instr, input, 32: current instruction register contents.
- mem_ready, input, 1: memory acknowledge for the current mem_req cycle.
- branch_taken, input, 1: branch comparison result from the ALU; valid in EXEC.
- mem_req, output, 1: memory access request.
- mem_we, output, 1: memory write (store).
- mem_addr_sel, output, 1: memory address select; 0 = PC, 1 = ALU result.
- ir_we, output, 1: instruction register load.
- pc_we, output, 1: PC update.
- pc_sel, output, 1: next-PC select; 0 = PC+4, 1 = PC+imm.
- reg_we, output, 1: register file write.
- wb_sel, output, 2: writeback select; 0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate.
- alu_src_b, output, 1: ALU B-operand select; 0 = rs2, 1 = immediate.
- alu_op, output, 2: 00 = add, 01 = compare, 10 = funct-decoded, 11 = pass B.
- instret, output, 1: one-cycle pulse when an instruction retires.
- illegal, output, 1: sticky illegal-instruction flag.
- bus_err, output, 1: sticky memory-timeout flag.
- state_o, output, 3: current FSM state (debug).

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset (asynchronous): state=FETCH, timeout counter=0, opclass=NONE, illegal=0, bus_err=0. While reset is high, all outputs read 0 (state_o reads 0).
- Control outputs are combinational functions of state, latched opclass, mem_ready and branch_taken. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1 in the same cycle, clear the counter, go to DECODE.
  - Otherwise the counter increments. On the cycle the counter equals MEM_TIMEOUT with mem_ready low: set bus_err, go to TRAP.
  - mem_ready on that same cycle wins over the timeout.
- DECODE: classify instr[6:0] and latch opclass.
  - Legal opcodes: LOAD 0000011, OPIMM 0010011, OP 0110011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111.
  - BRANCH with funct3 010 or 011 is illegal. Any other opcode is illegal.
  - Illegal: set illegal, go to TRAP. Otherwise go to EXEC.
- EXEC, by opclass:
  - OP: alu_op=10, alu_src_b=0; go to WB.
  - OPIMM: alu_op=10, alu_src_b=1; go to WB.
  - LOAD/STORE: alu_op=00, alu_src_b=1; go to MEM.
  - LUI: alu_op=11, alu_src_b=1; go to WB.
  - JAL: go to WB.
  - BRANCH: alu_op=01, alu_src_b=0, pc_we=1, pc_sel=branch_taken, instret=1; go to FETCH.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, alu_src_b=1, alu_op=00, mem_we=(opclass==STORE).
  - Same timeout rule as FETCH.
  - On mem_ready: STORE asserts pc_we=1, pc_sel=0, instret=1 and goes to FETCH. LOAD goes to WB.
- WB: reg_we=1, pc_we=1, instret=1; go to FETCH.
  - wb_sel: ALU for OP/OPIMM, memory for LOAD, PC+4 for JAL, immediate for LUI.
  - pc_sel=1 for JAL, else 0.
  - alu_op/alu_src_b are held at their EXEC values.
- TRAP: absorbing state; all enables 0; illegal/bus_err held. Only reset exits.
- Timing and boundaries:
  - Latency with zero-wait memory: ALU/LUI/JAL = 4 cycles, load = 5, store = 4, branch = 3.
  - Each memory wait cycle adds 1.
  - instr changing after DECODE has no effect on control.
  - Reset mid-instruction aborts with no further pc_we/reg_we/mem_req.
  - mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then zero-wait memory supplying ADDI x1,x0,5 (0x00500093): states 0,1,2,4,0; WB has reg_we=1, wb_sel=0, alu_src_b=1, alu_op=10; one instret pulse.
- LW (0x0000A103) with mem_ready delayed 3 cycles in MEM: MEM lasts 4 cycles with mem_addr_sel=1 and mem_we=0, then WB with wb_sel=1; total 8 cycles.
- BEQ (0x00000463) with branch_taken=1, then repeated with 0: EXEC shows pc_we=1 and pc_sel=1/0 respectively; no reg_we; 3-cycle instruction.
- Opcode 0x0000007F, then BRANCH funct3=010: TRAP with illegal=1; all outputs 0 for 20 cycles; reset clears the flag and returns to FETCH.
- mem_ready held low in FETCH with MEM_TIMEOUT=15: bus_err rises on the 16th FETCH cycle. Repeat with mem_ready arriving exactly on that cycle: goes to DECODE, bus_err=0.
- Assert reset during MEM of SW (0x0020A023): outputs go to 0 immediately; after release the first cycle is FETCH with mem_req=1 and no mem_we.
